// File: rtl/fifo_pkg.sv
// Shared widths and types for the 128-bit FIFO read-side drain stage.
// FIFO_DW/OUT_DW are the stage's DATA_W/OUT_W; FIFO_DW must be a multiple of OUT_DW.
package fifo_pkg;

    localparam int unsigned FIFO_DW = 128;
    localparam int unsigned OUT_DW  = 32;
    localparam int unsigned LANES   = FIFO_DW / OUT_DW;

    typedef logic [$clog2(LANES)-1:0] lane_t;
    typedef logic [FIFO_DW-1:0]       word_t;
    typedef logic [OUT_DW-1:0]        beat_t;
    typedef logic [1:0]               occ_t;

    localparam lane_t LAST_LANE = lane_t'(LANES - 1);

    function automatic beat_t lane_slice(input word_t w, input lane_t l);
        return w[l*OUT_DW +: OUT_DW];
    endfunction

endpackage

// File: rtl/fifo_rd_unpacker_if.sv
// FIFO read port plus output beat stream of the drain stage.
// master = the unpacker; slave = FIFO/downstream environment.
interface fifo_rd_unpacker_if;
    import fifo_pkg::*;

    logic  o_rden;
    logic  i_empty;
    word_t i_rddata;
    logic  m_valid;
    logic  m_ready;
    beat_t m_data;
    logic  m_last;

    modport master (
        output o_rden,
        input  i_empty,
        input  i_rddata,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        input  o_rden,
        output i_empty,
        output i_rddata,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/fifo_word_buf.sv
// Two-entry word buffer with 1-bit wrapping pointers and an occupancy count.
// Push and pop in the same cycle leave occ unchanged; push lands in the slot not being read.
module fifo_word_buf
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  word_t din,
    output word_t dout,
    output occ_t  occ
);

    word_t mem_q [2];
    logic  wr_ptr_q;
    logic  rd_ptr_q;
    occ_t  occ_q;
    occ_t  occ_d;

    always_comb begin
        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_d;
        end
    end

    // Data slots need no reset: occ gates everything that reads them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout = mem_q[rd_ptr_q];
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_unpacker.sv
// Drains the sync FIFO with credit-based reads and serialises each word into
// OUT_DW-bit beats, lane 0 first, on a valid/ready stream.
module fifo_rd_unpacker
    import fifo_pkg::*;
(
    input logic                clk,
    input logic                rst,
    fifo_rd_unpacker_if.master bus
);

    occ_t  occ;
    word_t head_word;
    logic  inflight_q;
    lane_t lane_q;
    lane_t lane_d;
    logic  rden;
    logic  xfer;
    logic  pop;

    // Credit counts buffered words plus the read still in the FIFO pipe, so a
    // returning word always has a free slot; m_ready never feeds this path.
    assign rden = !rst && !bus.i_empty && ((occ + occ_t'(inflight_q)) < 2'd2);

    assign bus.o_rden  = rden;
    assign bus.m_valid = (occ != '0);
    assign bus.m_data  = bus.m_valid ? lane_slice(head_word, lane_q) : '0;
    assign bus.m_last  = bus.m_valid && (lane_q == LAST_LANE);

    assign xfer = bus.m_valid && bus.m_ready;
    assign pop  = xfer && (lane_q == LAST_LANE);

    always_comb begin
        lane_d = lane_q;
        if (pop) begin
            lane_d = '0;
        end else if (xfer) begin
            lane_d = lane_q + lane_t'(1);
        end
    end

    // Reset drops inflight, so FIFO data returning after reset is never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            lane_q     <= '0;
        end else begin
            inflight_q <= rden;
            lane_q     <= lane_d;
        end
    end

    fifo_word_buf u_word_buf (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .pop  (pop),
        .din  (bus.i_rddata),
        .dout (head_word),
        .occ  (occ)
    );

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: FIFO model with 1-cycle read latency, beat scoreboard
// fed from words as they leave the FIFO, and a negedge monitor that pops and compares.
module tb_fifo_rd_unpacker;
    import fifo_pkg::*;

    typedef struct packed {
        beat_t data;
        logic  last;
    } beat_exp_t;

    logic clk = 1'b0;
    logic rst;

    fifo_rd_unpacker_if bus_if ();

    fifo_rd_unpacker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    word_t     fifo_q [$];
    beat_exp_t exp_q  [$];

    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    logic  rd_req   = 1'b0;
    int    outstanding = 0;
    int    rden_cnt = 0;
    int    xfer_cnt = 0;
    int    first_xfer = -1;
    int    last_xfer  = -1;
    logic  prev_stall = 1'b0;
    beat_t prev_data;
    logic  prev_last;

    localparam word_t W_PAT = 128'h0000000F_0000000E_0000000D_0000000C;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    endtask

    function automatic word_t rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // FIFO model: a read seen in cycle N presents its word during cycle N+1.
    always @(posedge clk) begin : fifo_model
        word_t w;
        #1;
        if (rd_req && fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            bus_if.i_rddata = w;
            outstanding++;
            for (int l = 0; l < int'(LANES); l++)
                exp_q.push_back('{data: w[l*OUT_DW +: OUT_DW], last: (l == int'(LANES) - 1)});
        end
        bus_if.i_empty = (fifo_q.size() == 0);
    end

    always @(negedge clk) begin : monitor
        beat_exp_t e;
        cyc++;
        if (!rst) begin
            check("no_read_when_empty", bus_if.o_rden && bus_if.i_empty, 1'b0);
            check("credit_le_2", (outstanding + int'(bus_if.o_rden)) <= 2, 1'b1);
            if (prev_stall) begin
                check("stall_valid_held", bus_if.m_valid, 1'b1);
                check("stall_data_held", bus_if.m_data, prev_data);
                check("stall_last_held", bus_if.m_last, prev_last);
            end
            if (bus_if.m_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got data 0x%0h, required no beat",
                             bus_if.m_data);
                end else begin
                    e = exp_q[0];
                    check("beat_data", bus_if.m_data, e.data);
                    check("beat_last", bus_if.m_last, e.last);
                    if (bus_if.m_ready) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                        if (first_xfer < 0) first_xfer = cyc;
                        last_xfer = cyc;
                        if (e.last) outstanding--;
                    end
                end
            end
            prev_stall = bus_if.m_valid && !bus_if.m_ready;
            prev_data  = bus_if.m_data;
            prev_last  = bus_if.m_last;
            if (bus_if.o_rden) rden_cnt++;
            rd_req = bus_if.o_rden;
        end else begin
            rd_req     = 1'b0;
            prev_stall = 1'b0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_word(input word_t w);
        fifo_q.push_back(w);
        bus_if.i_empty = 1'b0;
    endtask

    task automatic clear_stats();
        rden_cnt   = 0;
        xfer_cnt   = 0;
        first_xfer = -1;
        last_xfer  = -1;
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        exp_q.delete();
        outstanding = 0;
        rd_req = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            step(1);
            done = (exp_q.size() == 0) && (fifo_q.size() == 0) && (outstanding == 0)
                   && !bus_if.m_valid;
        end
        check({"drain_", name}, done, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        word_t w1;
        word_t w3;
        bit    found;
        int    viol;

        rst = 1'b1;
        bus_if.i_empty  = 1'b1;
        bus_if.i_rddata = '0;
        bus_if.m_ready  = 1'b0;
        step(3);
        @(negedge clk);
        check("rst_rden", bus_if.o_rden, 1'b0);
        check("rst_valid", bus_if.m_valid, 1'b0);
        check("rst_data", bus_if.m_data, '0);
        check("rst_last", bus_if.m_last, 1'b0);
        step(1);
        rst = 1'b0;
        step(2);

        // 1: single word, continuous ready
        clear_stats();
        bus_if.m_ready = 1'b1;
        push_word(W_PAT);
        drain("t1", 40);
        check("t1_rden_pulses", rden_cnt, 1);
        check("t1_beats", xfer_cnt, 4);
        check("t1_back_to_back", last_xfer - first_xfer, 3);

        // 2: eight words, continuous ready
        clear_stats();
        for (int i = 0; i < 8; i++) push_word(rand_word());
        drain("t2", 80);
        check("t2_rden_pulses", rden_cnt, 8);
        check("t2_beats", xfer_cnt, 32);
        check("t2_back_to_back", last_xfer - first_xfer, 31);

        // 3: four words with a 10-cycle stall
        clear_stats();
        bus_if.m_ready = 1'b0;
        push_word(W_PAT);
        for (int i = 0; i < 3; i++) push_word(rand_word());
        step(10);
        check("t3_rden_while_stalled", rden_cnt, 2);
        check("t3_stall_data", bus_if.m_data, 32'hC);
        bus_if.m_ready = 1'b1;
        drain("t3", 60);
        check("t3_beats", xfer_cnt, 16);
        check("t3_rden_total", rden_cnt, 4);

        // 4: empty FIFO for 20 cycles, then read latency
        clear_stats();
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.o_rden || bus_if.m_valid) viol++;
        end
        check("t4_idle_violations", viol, 0);
        step(1);
        push_word(rand_word());
        @(negedge clk);
        check("t4_rden_at_n", bus_if.o_rden, 1'b1);
        check("t4_valid_at_n", bus_if.m_valid, 1'b0);
        @(negedge clk);
        check("t4_valid_at_n1", bus_if.m_valid, 1'b0);
        @(negedge clk);
        check("t4_valid_at_n2", bus_if.m_valid, 1'b1);
        drain("t4", 40);

        // 5: reset at lane 2 of word 1 while the next read is inflight
        clear_stats();
        w1 = rand_word();
        w3 = rand_word();
        push_word(rand_word());
        push_word(w1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            found = (xfer_cnt == 5) && bus_if.m_valid;
        end
        check("t5_reach_lane1", found, 1'b1);
        push_word(rand_word());
        step(1);
        check("t5_lane2_data", bus_if.m_data, w1[2*OUT_DW +: OUT_DW]);
        assert_reset();
        #1;
        check("t5_rst_valid", bus_if.m_valid, 1'b0);
        check("t5_rst_rden", bus_if.o_rden, 1'b0);
        check("t5_rst_data", bus_if.m_data, '0);
        push_word(w3);
        @(negedge clk);
        check("t5_no_rden_in_rst", bus_if.o_rden, 1'b0);
        step(2);
        rst = 1'b0;
        clear_stats();
        drain("t5", 40);
        check("t5_beats_after_rst", xfer_cnt, 4);

        // 6: m_ready toggles every cycle over three words
        clear_stats();
        for (int i = 0; i < 3; i++) push_word(rand_word());
        bus_if.m_ready = 1'b0;
        for (int i = 0; i < 60 && (xfer_cnt < 12); i++) begin
            step(1);
            bus_if.m_ready = ~bus_if.m_ready;
        end
        bus_if.m_ready = 1'b1;
        drain("t6", 20);
        check("t6_beats", xfer_cnt, 12);

        // 7: random ready and random arrivals
        clear_stats();
        for (int i = 0, pushed = 0; i < 400; i++) begin
            step(1);
            bus_if.m_ready = ($urandom_range(0, 3) != 0);
            if (pushed < 20 && $urandom_range(0, 3) == 0) begin
                push_word(rand_word());
                pushed++;
            end
        end
        bus_if.m_ready = 1'b1;
        drain("t7", 200);
        check("t7_beats", xfer_cnt, 80);
        check("t7_rden_total", rden_cnt, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
